// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencer for the 5-stage core.
// Generates the write-enable, flush and bubble controls for PC, IF/ID, ID/EX,
// EX/MEM and MEM/WB. It handles four situations:
//   - the post-reset scrub of the pipeline registers
//   - load-use stalls
//   - taken-branch flushes
//   - data-memory wait states, with a watchdog that halts the core on timeout
// The pipeline registers have no reset of their own, so the scrub phase is
// what makes them safe.
//
// Parameters:
//   INIT_CYCLES  scrub cycles after reset release (1..15)
//   MEM_TIMEOUT  maximum MEM_WAIT cycles before halt (1..255)
// Ports:
//   clk_i, rst_n_i                       clock (rising edge), async active-low reset
//   rs_id_i, rt_id_i, uses_rs_i, uses_rt_i  source registers of the ID instruction
//   memread_ex_i, rd_ex_i                EX instruction is a load, and its destination
//   branch_taken_i                       branch resolved taken in ID
//   dmem_req_i, dmem_ack_i               data memory handshake in MEM
//   pc_write_o .. exmem_write_o          stage write enables (0 = hold)
//   ifid_flush_o, idex_bubble_o, memwb_bubble_o  NOP / zero-control injection
//   err_o                                sticky memory timeout
//   state_o                              0=INIT 1=RUN 2=MEM_WAIT 3=HALT
//   stall_cnt_o, flush_cnt_o             performance counters
// Build option:
//   HAZARD_PERF_EN  enables the performance counters. Without it, both
//                   counter ports are tied to 0.
module hazard_ctrl #(
  parameter int unsigned INIT_CYCLES = 4,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [4:0]  rs_id_i,
  input  logic [4:0]  rt_id_i,
  input  logic        uses_rs_i,
  input  logic        uses_rt_i,
  input  logic        memread_ex_i,
  input  logic [4:0]  rd_ex_i,
  input  logic        branch_taken_i,
  input  logic        dmem_req_i,
  input  logic        dmem_ack_i,
  output logic        pc_write_o,
  output logic        ifid_write_o,
  output logic        idex_write_o,
  output logic        exmem_write_o,
  output logic        ifid_flush_o,
  output logic        idex_bubble_o,
  output logic        memwb_bubble_o,
  output logic        err_o,
  output logic [1:0]  state_o,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
);

  typedef enum logic [1:0] {
    S_INIT     = 2'd0,
    S_RUN      = 2'd1,
    S_MEM_WAIT = 2'd2,
    S_HALT     = 2'd3
  } state_t;

  localparam logic [3:0] INIT_LAST = 4'(INIT_CYCLES - 1);
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT);

  state_t     state, state_next;
  logic [3:0] init_cnt, init_cnt_next;
  logic [7:0] wait_cnt, wait_cnt_next;
  logic       err, err_next;

  logic mem_stall;
  logic load_use;
  logic freeze;
  logic run_rules;

  assign mem_stall = dmem_req_i && !dmem_ack_i;
  assign load_use  = memread_ex_i && (rd_ex_i != 5'd0) &&
                     ((uses_rs_i && (rs_id_i == rd_ex_i)) ||
                      (uses_rt_i && (rt_id_i == rd_ex_i)));

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= S_INIT;
      init_cnt <= '0;
      wait_cnt <= '0;
      err      <= 1'b0;
    end else begin
      state    <= state_next;
      init_cnt <= init_cnt_next;
      wait_cnt <= wait_cnt_next;
      err      <= err_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next    = state;
    init_cnt_next = init_cnt;
    wait_cnt_next = wait_cnt;
    err_next      = err;
    unique case (state)
      S_INIT: begin
        if (init_cnt == INIT_LAST) state_next = S_RUN;
        else                       init_cnt_next = init_cnt + 4'd1;
      end
      S_RUN: begin
        if (mem_stall) begin
          state_next    = S_MEM_WAIT;
          wait_cnt_next = 8'd1;
        end
      end
      S_MEM_WAIT: begin
        // An ack that arrives on the timeout cycle takes priority over the halt.
        if (dmem_ack_i) begin
          state_next = S_RUN;
        end else if (wait_cnt == WAIT_LAST) begin
          state_next = S_HALT;
          err_next   = 1'b1;
        end else begin
          wait_cnt_next = wait_cnt + 8'd1;
        end
      end
      S_HALT: state_next = S_HALT;
      default: state_next = S_INIT;
    endcase
  end

  // Output logic
  // Freeze has the highest priority. The load-use and branch rules apply in RUN,
  // and in the MEM_WAIT cycle that receives the ack. That makes load-use
  // re-evaluate as soon as the freeze ends.
  assign freeze    = (state == S_HALT) ||
                     ((state == S_RUN) && mem_stall) ||
                     ((state == S_MEM_WAIT) && !dmem_ack_i);
  assign run_rules = !freeze && ((state == S_RUN) || (state == S_MEM_WAIT));

  always_comb begin
    pc_write_o     = 1'b1;
    ifid_write_o   = 1'b1;
    idex_write_o   = 1'b1;
    exmem_write_o  = 1'b1;
    ifid_flush_o   = 1'b0;
    idex_bubble_o  = 1'b0;
    memwb_bubble_o = 1'b0;
    if (state == S_INIT) begin
      pc_write_o     = 1'b0;
      ifid_flush_o   = 1'b1;
      idex_bubble_o  = 1'b1;
      memwb_bubble_o = 1'b1;
    end else if (freeze) begin
      pc_write_o     = 1'b0;
      ifid_write_o   = 1'b0;
      idex_write_o   = 1'b0;
      exmem_write_o  = 1'b0;
      memwb_bubble_o = 1'b1;
    end else if (run_rules) begin
      if (load_use) begin
        // The branch flush is held back; the branch is evaluated again next cycle.
        pc_write_o    = 1'b0;
        ifid_write_o  = 1'b0;
        idex_bubble_o = 1'b1;
      end else if (branch_taken_i) begin
        ifid_flush_o = 1'b1;
      end
    end
  end

  assign err_o   = err;
  assign state_o = state;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_write_o && ((state == S_RUN) || (state == S_MEM_WAIT)))
        stall_cnt <= stall_cnt + 32'd1;
      if (ifid_flush_o && (state == S_RUN))
        flush_cnt <= flush_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt;
  assign flush_cnt_o = flush_cnt;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl (INIT_CYCLES=4, MEM_TIMEOUT=8).
// The driver applies one directed vector per cycle and queues the expected controls.
// The monitor pops an entry at each falling edge and compares it with the DUT outputs.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs_id, rt_id, rd_ex;
  logic        uses_rs, uses_rt, memread_ex, branch_taken, dmem_req, dmem_ack;
  logic        pc_write, ifid_write, idex_write, exmem_write;
  logic        ifid_flush, idex_bubble, memwb_bubble, err;
  logic [1:0]  state;
  logic [31:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  hazard_ctrl #(.INIT_CYCLES(4), .MEM_TIMEOUT(8)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .rs_id_i(rs_id), .rt_id_i(rt_id), .uses_rs_i(uses_rs), .uses_rt_i(uses_rt),
    .memread_ex_i(memread_ex), .rd_ex_i(rd_ex), .branch_taken_i(branch_taken),
    .dmem_req_i(dmem_req), .dmem_ack_i(dmem_ack),
    .pc_write_o(pc_write), .ifid_write_o(ifid_write), .idex_write_o(idex_write),
    .exmem_write_o(exmem_write), .ifid_flush_o(ifid_flush), .idex_bubble_o(idex_bubble),
    .memwb_bubble_o(memwb_bubble), .err_o(err), .state_o(state),
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
  );

  // Pattern bit order: pc_w ifid_w idex_w exmem_w flush idex_bubble memwb_bubble
  localparam logic [6:0] P_INIT = 7'b0111_111;
  localparam logic [6:0] P_RUN  = 7'b1111_000;
  localparam logic [6:0] P_FRZ  = 7'b0000_001;
  localparam logic [6:0] P_LU   = 7'b0011_010;
  localparam logic [6:0] P_BR   = 7'b1111_100;

  typedef struct packed {
    logic [9:0]  ctl;
    logic [31:0] stall;
    logic [31:0] flush;
  } exp_t;

  exp_t q[$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [31:0] tally_stall = '0;
  logic [31:0] tally_flush = '0;

  // Monitor
  initial begin
    exp_t e;
    logic [9:0] act;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        act = {pc_write, ifid_write, idex_write, exmem_write, ifid_flush,
               idex_bubble, memwb_bubble, err, state};
        checks++;
        if (act !== e.ctl) begin
          errors++;
          $display("FAIL ctl @%0t: got %b expected %b", $time, act, e.ctl);
        end
        checks++;
        if (stall_cnt !== e.stall || flush_cnt !== e.flush) begin
          errors++;
          $display("FAIL perf @%0t: got stall=%0d flush=%0d expected stall=%0d flush=%0d",
                   $time, stall_cnt, flush_cnt, e.stall, e.flush);
        end
      end
    end
  end

  // Apply one cycle of stimulus together with its expected response.
  task automatic cyc(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                     input logic urt, input logic mr, input logic [4:0] rd,
                     input logic br, input logic req, input logic ack,
                     input logic [6:0] pat, input logic e_err, input logic [1:0] st);
    exp_t e;
    rs_id = rs; rt_id = rt; uses_rs = urs; uses_rt = urt;
    memread_ex = mr; rd_ex = rd; branch_taken = br; dmem_req = req; dmem_ack = ack;
    if (!rst_n) begin
      tally_stall = '0;
      tally_flush = '0;
    end
    e.ctl = {pat, e_err, st};
`ifdef HAZARD_PERF_EN
    e.stall = tally_stall;
    e.flush = tally_flush;
    if (!pat[6] && (st == 2'd1 || st == 2'd2)) tally_stall = tally_stall + 32'd1;
    if (pat[2] && st == 2'd1) tally_flush = tally_flush + 32'd1;
`else
    e.stall = '0;
    e.flush = '0;
`endif
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [6:0] pat, input logic e_err, input logic [1:0] st,
                      input int unsigned n);
    for (int unsigned i = 0; i < n; i++)
      cyc(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, pat, e_err, st);
  endtask

  task automatic mem(input logic ack, input logic [6:0] pat, input logic e_err,
                     input logic [1:0] st, input int unsigned n);
    for (int unsigned i = 0; i < n; i++)
      cyc(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, ack, pat, e_err, st);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    rs_id = '0; rt_id = '0; rd_ex = '0;
    uses_rs = 0; uses_rt = 0; memread_ex = 0; branch_taken = 0; dmem_req = 0; dmem_ack = 0;
    @(posedge clk); #1;

    // Reset held, then release: 4 scrub cycles, then RUN
    idle(P_INIT, 0, 2'd0, 2);
    rst_n = 1'b1;
    idle(P_INIT, 0, 2'd0, 4);
    idle(P_RUN, 0, 2'd1, 1);

    // Load-use on RS: one stall cycle, then normal
    cyc(5'd5, 5'd0, 1, 0, 1, 5'd5, 0, 0, 0, P_LU, 0, 2'd1);
    idle(P_RUN, 0, 2'd1, 1);
    // rd=0 never stalls
    cyc(5'd0, 5'd0, 1, 0, 1, 5'd0, 0, 0, 0, P_RUN, 0, 2'd1);
    // Match on RT only
    cyc(5'd1, 5'd7, 0, 1, 1, 5'd7, 0, 0, 0, P_LU, 0, 2'd1);
    // RS matches but is unused: no stall
    cyc(5'd7, 5'd3, 0, 1, 1, 5'd7, 0, 0, 0, P_RUN, 0, 2'd1);
    // Load-use with a branch: no flush. Branch alone next cycle: flush
    cyc(5'd9, 5'd0, 1, 0, 1, 5'd9, 1, 0, 0, P_LU, 0, 2'd1);
    cyc(5'd9, 5'd0, 1, 0, 0, 5'd9, 1, 0, 0, P_BR, 0, 2'd1);

    // Memory access acknowledged after three cycles of waiting
    mem(0, P_FRZ, 0, 2'd1, 1);
    mem(0, P_FRZ, 0, 2'd2, 2);
    mem(1, P_RUN, 0, 2'd2, 1);
    idle(P_RUN, 0, 2'd1, 1);
    // Ack in the same cycle as the request: no stall
    mem(1, P_RUN, 0, 2'd1, 1);

    // Freeze beats load-use; load-use applies on the ack cycle
    cyc(5'd4, 5'd0, 1, 0, 1, 5'd4, 0, 1, 0, P_FRZ, 0, 2'd1);
    cyc(5'd4, 5'd0, 1, 0, 1, 5'd4, 0, 1, 1, P_LU, 0, 2'd2);
    idle(P_RUN, 0, 2'd1, 1);

    // Ack arrives on the exact timeout cycle (wait_cnt == 8)
    mem(0, P_FRZ, 0, 2'd1, 1);
    mem(0, P_FRZ, 0, 2'd2, 7);
    mem(1, P_RUN, 0, 2'd2, 1);
    idle(P_RUN, 0, 2'd1, 1);

    // Reset during MEM_WAIT aborts straight to INIT
    mem(0, P_FRZ, 0, 2'd1, 1);
    mem(0, P_FRZ, 0, 2'd2, 1);
    rst_n = 1'b0;
    mem(0, P_INIT, 0, 2'd0, 1);
    rst_n = 1'b1;
    idle(P_INIT, 0, 2'd0, 4);
    idle(P_RUN, 0, 2'd1, 1);

    // Timeout: 8 MEM_WAIT cycles, then HALT with err set; a late ack does not release it
    mem(0, P_FRZ, 0, 2'd1, 1);
    mem(0, P_FRZ, 0, 2'd2, 8);
    mem(0, P_FRZ, 1, 2'd3, 2);
    mem(1, P_FRZ, 1, 2'd3, 1);
    cyc(5'd5, 5'd0, 1, 0, 1, 5'd5, 1, 0, 0, P_FRZ, 1, 2'd3);

    // Reset leaves HALT and clears err
    rst_n = 1'b0;
    idle(P_INIT, 0, 2'd0, 1);
    rst_n = 1'b1;
    idle(P_INIT, 0, 2'd0, 4);
    idle(P_RUN, 0, 2'd1, 1);
    cyc(5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, 0, P_BR, 0, 2'd1);

    @(negedge clk); #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
